// File: rtl/simon_gfx_pkg.sv
// Shared graphics definitions for the Simon tile renderer.
//   SCREEN_W / SCREEN_H : drawable area of the VGA adapter, in pixels.
//   colour_t, BLACK, WHITE, PALETTE : 3-bit RGB colour codes.
//   state_t : renderer FSM states.
//   base_colour() : resting colour of a tile, chosen from its index.
package simon_gfx_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [2:0] colour_t;

  localparam colour_t BLACK = 3'd0;
  localparam colour_t WHITE = 3'd7;

  // Entry k sits at bits [3k+2:3k]: blue, green, red, yellow.
  localparam logic [11:0] PALETTE = {3'd6, 3'd4, 3'd2, 3'd1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FULL,
    ST_TILE,
    ST_FIN
  } state_t;

  function automatic colour_t base_colour(input int idx);
    return PALETTE[(idx % 4) * 3 +: 3];
  endfunction

endpackage

// File: rtl/simon_tile_renderer_if.sv
// Pixel plot bus between the tile renderer and the VGA adapter.
//   outX      : pixel x (0..159)
//   outY      : pixel y (0..119)
//   outColour : 3-bit pixel colour
//   plot      : write strobe, one pixel per asserted cycle
// master = renderer side, slave = VGA adapter side.
interface simon_tile_renderer_if;
  import simon_gfx_pkg::*;

  logic [7:0] outX;
  logic [6:0] outY;
  colour_t    outColour;
  logic       plot;

  modport master (output outX, output outY, output outColour, output plot);
  modport slave  (input  outX, input  outY, input  outColour, input  plot);

endinterface

// File: rtl/simon_tile_scanner.sv
// Pixel walker for one tile at a time.
//   CLOCK_50, reset : clock, synchronous active-high reset
//   adv             : step to the next pixel (one per cycle while drawing)
//   tile_idx        : tile being drawn, sets the screen origin
//   cur_idx, cur_en : tile holding the visible cursor box
//   out_x, out_y    : screen coordinate of the current pixel
//   last_pixel      : current pixel is the tile's bottom-right pixel
//   in_cursor       : current pixel lies inside the cursor box
//   on_border       : current pixel is on the tile's outer ring
//                     (present only when SIMON_TILE_BORDER_EN is defined)
// The px/py counters wrap to zero after the last pixel, so consecutive tiles
// in a full pass follow each other without a gap cycle.
module simon_tile_scanner
  import simon_gfx_pkg::*;
#(
  parameter int COLS   = 2,
  parameter int TILE_W = 80,
  parameter int TILE_H = 60,
  parameter int CUR_W  = 16,
  parameter int CUR_H  = 16,
  parameter int NT     = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  adv,
  input  logic [$clog2(NT)-1:0] tile_idx,
  input  logic [$clog2(NT)-1:0] cur_idx,
  input  logic                  cur_en,
  output logic [7:0]            out_x,
  output logic [6:0]            out_y,
  output logic                  last_pixel,
`ifdef SIMON_TILE_BORDER_EN
  output logic                  on_border,
`endif
  output logic                  in_cursor
);

  localparam int PXW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int PYW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int CX0 = (TILE_W - CUR_W) / 2;
  localparam int CY0 = (TILE_H - CUR_H) / 2;

  logic [PXW-1:0] px;
  logic [PYW-1:0] py;
  logic           px_last;
  logic           py_last;

  assign px_last = (px == PXW'(TILE_W - 1));
  assign py_last = (py == PYW'(TILE_H - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      px <= '0;
      py <= '0;
    end else if (adv) begin
      if (px_last) begin
        px <= '0;
        py <= py_last ? '0 : py + 1'b1;
      end else begin
        px <= px + 1'b1;
      end
    end
  end

  assign last_pixel = px_last && py_last;

  assign out_x = 8'((int'(tile_idx) % COLS) * TILE_W + int'(px));
  assign out_y = 7'((int'(tile_idx) / COLS) * TILE_H + int'(py));

  assign in_cursor = cur_en && (cur_idx == tile_idx) &&
                     (int'(px) >= CX0) && (int'(px) < CX0 + CUR_W) &&
                     (int'(py) >= CY0) && (int'(py) < CY0 + CUR_H);

`ifdef SIMON_TILE_BORDER_EN
  assign on_border = (px == '0) || px_last || (py == '0) || py_last;
`endif

endmodule

// File: rtl/simon_tile_renderer.sv
// Simon board tile renderer: draws a COLS x ROWS grid of coloured tiles,
// white flashing tiles and a black cursor box, one pixel per cycle, and
// redraws only tiles whose displayed state changed since they were drawn.
//   CLOCK_50   : clock
//   reset      : synchronous active-high reset; arms a full redraw
//   redraw_all : pulse, request a full-screen redraw (sticky)
//   flash_mask : bit i set shows tile i white
//   cursor_en  : cursor box visible
//   cursor_sel : tile index holding the cursor (values >= NT are ignored)
//   vga        : plot bus (outX, outY, outColour, plot) to the VGA adapter
//   busy       : a tile or full pass is being drawn
//   done       : one-cycle pulse when drawing goes idle
// Build option: define SIMON_TILE_BORDER_EN to draw a black one-pixel ring
// around every tile; undefined, tiles are solid edge to edge.
module simon_tile_renderer
  import simon_gfx_pkg::*;
#(
  parameter int COLS   = 2,
  parameter int ROWS   = 2,
  parameter int TILE_W = 80,
  parameter int TILE_H = 60,
  parameter int CUR_W  = 16,
  parameter int CUR_H  = 16,
  parameter int NT     = COLS * ROWS
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   redraw_all,
  input  logic [NT-1:0]          flash_mask,
  input  logic                   cursor_en,
  input  logic [$clog2(NT)-1:0]  cursor_sel,
  simon_tile_renderer_if.master  vga,
  output logic                   busy,
  output logic                   done
);

  localparam int IW = $clog2(NT);
  typedef logic [IW-1:0] idx_t;

  if (COLS * TILE_W > SCREEN_W || ROWS * TILE_H > SCREEN_H ||
      CUR_W > TILE_W || CUR_H > TILE_H || NT < 2) begin : g_bad_geometry
    $error("simon_tile_renderer: tile grid or cursor box does not fit");
  end

  state_t   state, state_n;
  idx_t     tile_idx, load_idx, low_idx, drawn_cur;
  logic     drawn_cur_en, full_pending;
  logic     sel_ok, cur_change;
  logic     load, tile_start, full_start;
  logic     plotting, last_pixel, in_cursor;
  logic [NT-1:0] drawn_mask, cur_dirty, chg_bits, dirty;
  colour_t  tile_clr, pix_clr;
  logic [7:0] scan_x;
  logic [6:0] scan_y;
`ifdef SIMON_TILE_BORDER_EN
  logic     on_border;
`endif

  // A cursor move dirties both the tile it leaves and the tile it enters.
  // The second tile is remembered in cur_dirty because drawn_cur is updated
  // as soon as the first of the two redraws starts.
  assign sel_ok     = ({1'b0, cursor_sel} < (IW + 1)'(NT));
  assign cur_change = sel_ok &&
                      ((cursor_en != drawn_cur_en) || (cursor_sel != drawn_cur));
  assign chg_bits   = cur_change ? ((NT'(1) << drawn_cur) | (NT'(1) << cursor_sel))
                                 : '0;
  assign dirty      = (flash_mask ^ drawn_mask) | cur_dirty | chg_bits;

  always_comb begin
    low_idx = '0;
    for (int i = NT - 1; i >= 0; i--) begin
      if (dirty[i]) low_idx = idx_t'(i);
    end
  end

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    load_idx   = tile_idx;
    tile_start = 1'b0;
    full_start = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (full_pending) begin
          state_n    = ST_FULL;
          full_start = 1'b1;
        end else if (|dirty) begin
          state_n    = ST_TILE;
          tile_start = 1'b1;
          load       = 1'b1;
          load_idx   = low_idx;
        end
      end
      ST_FULL: begin
        if (last_pixel) begin
          if (tile_idx != idx_t'(NT - 1)) begin
            load     = 1'b1;
            load_idx = tile_idx + 1'b1;
          end else if (full_pending) begin
            full_start = 1'b1;
          end else begin
            state_n = ST_FIN;
          end
        end
      end
      ST_TILE: begin
        // A pending full redraw follows straight on, so only one done
        // pulse marks the end of the combined drawing run.
        if (last_pixel) begin
          if (full_pending) begin
            state_n    = ST_FULL;
            full_start = 1'b1;
          end else begin
            state_n = ST_FIN;
          end
        end
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (full_start) begin
      load     = 1'b1;
      load_idx = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= ST_IDLE;
      full_pending <= 1'b1;
      tile_idx     <= '0;
      drawn_mask   <= '0;
      drawn_cur    <= '0;
      drawn_cur_en <= 1'b0;
      cur_dirty    <= '0;
    end else begin
      state <= state_n;
      if (full_start) full_pending <= 1'b0;
      if (redraw_all) full_pending <= 1'b1;
      if (load) begin
        tile_idx             <= load_idx;
        drawn_mask[load_idx] <= flash_mask[load_idx];
      end
      if (full_start) begin
        cur_dirty <= '0;
        if (sel_ok) begin
          drawn_cur    <= cursor_sel;
          drawn_cur_en <= cursor_en;
        end
      end else if (tile_start) begin
        cur_dirty <= (cur_dirty | chg_bits) & ~(NT'(1) << load_idx);
        if (cur_change) begin
          drawn_cur    <= cursor_sel;
          drawn_cur_en <= cursor_en;
        end
      end
    end
  end

  // Tile colour is frozen at tile start; later mask changes only re-dirty it.
  always_ff @(posedge CLOCK_50) begin
    if (load) tile_clr <= flash_mask[load_idx] ? WHITE : base_colour(int'(load_idx));
  end

  simon_tile_scanner #(
    .COLS   (COLS),
    .TILE_W (TILE_W),
    .TILE_H (TILE_H),
    .CUR_W  (CUR_W),
    .CUR_H  (CUR_H),
    .NT     (NT)
  ) u_scanner (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .adv        (plotting),
    .tile_idx   (tile_idx),
    .cur_idx    (drawn_cur),
    .cur_en     (drawn_cur_en),
    .out_x      (scan_x),
    .out_y      (scan_y),
    .last_pixel (last_pixel),
`ifdef SIMON_TILE_BORDER_EN
    .on_border  (on_border),
`endif
    .in_cursor  (in_cursor)
  );

  always_comb begin
`ifdef SIMON_TILE_BORDER_EN
    pix_clr = (in_cursor || on_border) ? BLACK : tile_clr;
`else
    pix_clr = in_cursor ? BLACK : tile_clr;
`endif
  end

  assign plotting      = (state == ST_FULL) || (state == ST_TILE);
  assign busy          = plotting;
  assign done          = (state == ST_FIN);
  assign vga.plot      = plotting;
  assign vga.outX      = scan_x;
  assign vga.outY      = scan_y;
  assign vga.outColour = plotting ? pix_clr : BLACK;

endmodule

// File: tb/tb_simon_tile_renderer.sv
// Directed bench for simon_tile_renderer with the default 2x2 geometry.
module tb_simon_tile_renderer;
  import simon_gfx_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       redraw_all;
  logic [3:0] flash_mask;
  logic       cursor_en;
  logic [1:0] cursor_sel;
  logic       busy;
  logic       done;

  simon_tile_renderer_if vga();

  simon_tile_renderer dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .redraw_all (redraw_all),
    .flash_mask (flash_mask),
    .cursor_en  (cursor_en),
    .cursor_sel (cursor_sel),
    .vga        (vga),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] fb [0:159][0:119];
  int cnt_col [8];
  int xmin, xmax, ymin, ymax;
  int plots, first, dones, p1, extra;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Runs until a done pulse or the cycle budget expires, recording every
  // plotted pixel. act: 1 = flip flash_mask[1], 2 = pulse redraw_all,
  // 3 = assert reset and return, all applied right after plot number act_at.
  task automatic run_draw(input int budget, input int act_at, input int act,
                          output int n_plot, output int n_first, output int n_done);
    int x, y;
    n_plot = 0; n_first = 0; n_done = 0;
    for (int c = 0; c < 8; c++) cnt_col[c] = 0;
    xmin = 999; xmax = -1; ymin = 999; ymax = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge CLOCK_50);
      redraw_all = 1'b0;
      if (done) begin
        n_done++;
        break;
      end
      if (vga.plot) begin
        n_plot++;
        if (n_first == 0) n_first = i;
        x = int'(vga.outX);
        y = int'(vga.outY);
        if (x < 160 && y < 120) fb[x][y] = vga.outColour;
        cnt_col[vga.outColour]++;
        if (x < xmin) xmin = x;
        if (x > xmax) xmax = x;
        if (y < ymin) ymin = y;
        if (y > ymax) ymax = y;
        if (n_plot == act_at) begin
          if (act == 1) flash_mask[1] = ~flash_mask[1];
          else if (act == 2) redraw_all = 1'b1;
          else if (act == 3) begin
            reset = 1'b1;
            break;
          end
        end
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    redraw_all = 1'b0;
    flash_mask = 4'b0000;
    cursor_en  = 1'b0;
    cursor_sel = 2'd0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_plot",   vga.plot, 0);
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    check("rst_outX",   vga.outX, 0);
    check("rst_outY",   vga.outY, 0);
    check("rst_colour", vga.outColour, 0);

    // Full redraw after reset release
    reset = 1'b0;
    run_draw(20000, 0, 0, plots, first, dones);
    check("full_plots", plots, 19200);
    check("full_done",  dones, 1);
    check("full_lat",   first, 1);
    check("pix_0_0",     fb[0][0], 1);
    check("pix_79_59",   fb[79][59], 1);
    check("pix_80_0",    fb[80][0], 2);
    check("pix_0_60",    fb[0][60], 4);
    check("pix_159_119", fb[159][119], 6);
    @(negedge CLOCK_50);
    check("done_single", done, 0);
    check("idle_busy",   busy, 0);

    // Flash tile 2, then clear it
    flash_mask = 4'b0100;
    run_draw(6000, 0, 0, plots, first, dones);
    check("flash_plots", plots, 4800);
    check("flash_done",  dones, 1);
    check("flash_lat",   first, 1);
    check("flash_white", cnt_col[7], 4800);
    check("flash_xmin",  xmin, 0);
    check("flash_xmax",  xmax, 79);
    check("flash_ymin",  ymin, 60);
    check("flash_ymax",  ymax, 119);
    flash_mask = 4'b0000;
    run_draw(6000, 0, 0, plots, first, dones);
    check("unflash_plots", plots, 4800);
    check("unflash_red",   cnt_col[4], 4800);

    // Cursor onto tile 0
    cursor_en  = 1'b1;
    cursor_sel = 2'd0;
    run_draw(6000, 0, 0, plots, first, dones);
    check("cur0_plots", plots, 4800);
    check("cur0_black", cnt_col[0], 256);
    check("cur0_blue",  cnt_col[1], 4544);
    check("cur0_tl",    fb[32][22], 0);
    check("cur0_br",    fb[47][37], 0);
    check("cur0_left",  fb[31][30], 1);
    check("cur0_right", fb[48][30], 1);
    check("cur0_above", fb[40][21], 1);
    check("cur0_below", fb[40][38], 1);

    // Cursor moves to tile 3: old tile first, then the new one
    cursor_sel = 2'd3;
    run_draw(6000, 0, 0, plots, first, dones);
    check("curmv_old_plots", plots, 4800);
    check("curmv_old_blue",  cnt_col[1], 4800);
    check("curmv_old_xmax",  xmax, 79);
    run_draw(6000, 0, 0, plots, first, dones);
    check("curmv_new_plots", plots, 4800);
    check("curmv_new_xmin",  xmin, 80);
    check("curmv_new_ymin",  ymin, 60);
    check("curmv_new_black", cnt_col[0], 256);
    check("cur3_tl",    fb[112][82], 0);
    check("cur3_br",    fb[127][97], 0);
    check("cur3_left",  fb[111][90], 6);
    check("cur3_right", fb[128][90], 6);

    // Flash bit toggles back while tile 1 is mid-draw
    flash_mask = 4'b0010;
    run_draw(6000, 100, 1, plots, first, dones);
    p1 = plots;
    check("tog_first_plots", plots, 4800);
    check("tog_first_white", cnt_col[7], 4800);
    check("tog_first_xmin",  xmin, 80);
    run_draw(6000, 0, 0, plots, first, dones);
    check("tog_second_green", cnt_col[2], 4800);
    check("tog_total", p1 + plots, 9600);

    // redraw_all during a tile-2 redraw
    flash_mask = 4'b0100;
    run_draw(30000, 200, 2, plots, first, dones);
    check("rdall_plots", plots, 24000);
    check("rdall_done",  dones, 1);
    check("rdall_white", cnt_col[7], 9600);
    check("rdall_black", cnt_col[0], 256);
    check("rdall_pix_0_60", fb[0][60], 7);
    extra = 0;
    repeat (5) begin
      @(negedge CLOCK_50);
      if (done || vga.plot) extra++;
    end
    check("rdall_quiet", extra, 0);

    // Reset in the middle of a tile redraw
    flash_mask = 4'b0000;
    run_draw(3000, 1000, 3, plots, first, dones);
    check("mid_rst_plots", plots, 1000);
    check("mid_rst_nodone", dones, 0);
    @(negedge CLOCK_50);
    check("mid_rst_plot", vga.plot, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_outX", vga.outX, 0);
    reset = 1'b0;
    run_draw(200, 0, 0, plots, first, dones);
    check("restart_plots", plots, 200);
    check("restart_lat",   first, 1);
    check("restart_blue",  cnt_col[1], 200);
    check("restart_nodone", dones, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
